icache_dm_param: RTL and testbench

- Parametrised direct-mapped instruction cache between the PC/fetch stage and instruction memory.
- Successor to the fixed 256x128-bit cache, with configurable depth, line size and word width.
- Proper multi-beat refill FSM that fills every word of a line before validating it.
- Also adds fetch/valid handshaking, a stall output and a whole-cache flush.

---
 rtl/icache_pkg.sv | 33 +++
 rtl/icache_refill_ctrl.sv | 63 ++++++
 rtl/icache_dm_param.sv | 158 +++++++++++++++
 tb/tb_icache_dm_param.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared state encoding and address-split helpers for icache_dm_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int c_STATS_W = 32;

  function automatic int calc_boff(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic int calc_woff(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int word_w,
                                    input int index_bits, input int words_per_line);
    return addr_w - calc_boff(word_w) - calc_woff(words_per_line) - index_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// Module   : icache_refill_ctrl
// Purpose  : Beat sequencer for line refills; issues memory beats and strobes
//            each accepted beat into the data array. Aborts on flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic                                    start,
  input  logic [ADDR_W-1:0]                       line_base,
  input  logic                                    memory_ready,
  output logic                                    memory_request,
  output logic [ADDR_W-1:0]                       memory_addr,
  output logic                                    beat_we,
  output logic [calc_woff(WORDS_PER_LINE)-1:0]    beat_idx,
  output logic                                    last_beat
);

  localparam int                c_WOFF       = calc_woff(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] c_BEAT_BYTES = ADDR_W'(WORD_W / 8);
  localparam logic [c_WOFF-1:0] c_LAST_BEAT  = c_WOFF'(WORDS_PER_LINE - 1);

  logic [c_WOFF-1:0] r_cnt;

  // A beat landing in the flush cycle is dropped so the line never completes.
  assign beat_we   = memory_request && memory_ready && !flush;
  assign beat_idx  = r_cnt;
  assign last_beat = beat_we && (r_cnt == c_LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      memory_request <= 1'b0;
      memory_addr    <= '0;
    end else if (flush) begin
      r_cnt          <= '0;
      memory_request <= 1'b0;
    end else if (start) begin
      r_cnt          <= '0;
      memory_request <= 1'b1;
      memory_addr    <= line_base;
    end else if (beat_we) begin
      r_cnt       <= r_cnt + c_WOFF'(1);
      memory_addr <= memory_addr + c_BEAT_BYTES;
      if (last_beat) begin
        memory_request <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache_dm_param.sv
// ============================================================================
// Module   : icache_dm_param
// Purpose  : Parametrised direct-mapped read-only instruction cache with
//            multi-beat refill. Optional hit/miss counters: ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_dm_param
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int WORD_W         = 32,
  parameter int INDEX_BITS     = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 flush,
  output logic [WORD_W-1:0]    instruction,
  output logic                 instr_valid,
  output logic                 hit,
  output logic                 stall,
  output logic                 memory_request,
  output logic [ADDR_W-1:0]    memory_addr,
  input  logic                 memory_ready,
  input  logic [WORD_W-1:0]    memory_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [c_STATS_W-1:0] hit_count,
  output logic [c_STATS_W-1:0] miss_count
`endif
);

  localparam int c_BOFF  = calc_boff(WORD_W);
  localparam int c_WOFF  = calc_woff(WORDS_PER_LINE);
  localparam int c_TAG_W = calc_tag_w(ADDR_W, WORD_W, INDEX_BITS, WORDS_PER_LINE);
  localparam int c_LINES = 1 << INDEX_BITS;

  state_t r_state, w_state_next;

  logic [WORD_W-1:0]     r_data  [c_LINES][WORDS_PER_LINE];
  logic [c_TAG_W-1:0]    r_tag   [c_LINES];
  logic [c_LINES-1:0]    r_valid;

  logic [INDEX_BITS-1:0] w_idx, r_req_idx;
  logic [c_WOFF-1:0]     w_word, r_req_word;
  logic [c_TAG_W-1:0]    w_tag, r_req_tag;
  logic [ADDR_W-1:0]     w_line_base;
  logic                  w_lookup, w_hit, w_miss;
  logic                  w_beat_we, w_last_beat;
  logic [c_WOFF-1:0]     w_beat_idx;

  assign w_idx       = address[c_BOFF+c_WOFF +: INDEX_BITS];
  assign w_word      = address[c_BOFF +: c_WOFF];
  assign w_tag       = address[ADDR_W-1 -: c_TAG_W];
  assign w_line_base = {address[ADDR_W-1:c_BOFF+c_WOFF], {(c_BOFF+c_WOFF){1'b0}}};

  generate
    if (c_BOFF > 0) begin : g_addr_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^address[c_BOFF-1:0];
    end
  endgenerate

  assign w_lookup = (r_state == IDLE) && fetch_valid && !flush;
  assign w_hit    = w_lookup && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss   = w_lookup && !w_hit;
  assign stall    = (r_state == REFILL);

  icache_refill_ctrl #(
    .ADDR_W         (ADDR_W),
    .WORD_W         (WORD_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .start          (w_miss),
    .line_base      (w_line_base),
    .memory_ready   (memory_ready),
    .memory_request (memory_request),
    .memory_addr    (memory_addr),
    .beat_we        (w_beat_we),
    .beat_idx       (w_beat_idx),
    .last_beat      (w_last_beat)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_state_next = REFILL;
      REFILL:  if (flush) w_state_next = IDLE;
               else if (w_last_beat) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_req_idx  <= w_idx;
      r_req_word <= w_word;
      r_req_tag  <= w_tag;
    end
    if (w_beat_we) r_data[r_req_idx][w_beat_idx] <= memory_data;
    if (w_last_beat) r_tag[r_req_idx] <= r_req_tag;
  end

  // The victim line is invalidated at miss time so a partial fill is never hit.
  always_ff @(posedge clk) begin
    if (reset || flush)   r_valid <= '0;
    else if (w_miss)      r_valid[w_idx] <= 1'b0;
    else if (w_last_beat) r_valid[r_req_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= '0;
      instr_valid <= 1'b0;
      hit         <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      hit         <= 1'b0;
      if (w_hit) begin
        instruction <= r_data[w_idx][w_word];
        instr_valid <= 1'b1;
        hit         <= 1'b1;
      end else if (w_last_beat) begin
        instruction <= (w_beat_idx == r_req_word) ? memory_data
                                                  : r_data[r_req_idx][r_req_word];
        instr_valid <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit && (hit_count != '1))   hit_count  <= hit_count + c_STATS_W'(1);
      if (w_miss && (miss_count != '1)) miss_count <= miss_count + c_STATS_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_dm_param.sv
// ============================================================================
// Module   : tb_icache_dm_param
// Purpose  : Directed self-checking bench for icache_dm_param (default and
//            8-word-line configurations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_dm_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration DUT signals
  logic        rst_a, fv_a, flush_a, rdy_a;
  logic [63:0] addr_a;
  logic [31:0] data_a;
  logic [31:0] instr_a;
  logic        iv_a, hit_a, stall_a, req_a;
  logic [63:0] maddr_a;

  // 8-word-line / 16-line DUT signals
  logic        rst_b, fv_b, flush_b, rdy_b;
  logic [63:0] addr_b;
  logic [31:0] data_b;
  logic [31:0] instr_b;
  logic        iv_b, hit_b, stall_b, req_b;
  logic [63:0] maddr_b;

`ifdef ICACHE_STATS_EN
  logic [31:0] hc_a, mc_a, hc_b, mc_b;
`endif

  icache_dm_param u_dut_a (
    .clk            (clk),
    .reset          (rst_a),
    .fetch_valid    (fv_a),
    .address        (addr_a),
    .flush          (flush_a),
    .instruction    (instr_a),
    .instr_valid    (iv_a),
    .hit            (hit_a),
    .stall          (stall_a),
    .memory_request (req_a),
    .memory_addr    (maddr_a),
    .memory_ready   (rdy_a),
    .memory_data    (data_a)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count      (hc_a),
    .miss_count     (mc_a)
`endif
  );

  icache_dm_param #(
    .ADDR_W         (64),
    .WORD_W         (32),
    .INDEX_BITS     (4),
    .WORDS_PER_LINE (8)
  ) u_dut_b (
    .clk            (clk),
    .reset          (rst_b),
    .fetch_valid    (fv_b),
    .address        (addr_b),
    .flush          (flush_b),
    .instruction    (instr_b),
    .instr_valid    (iv_b),
    .hit            (hit_b),
    .stall          (stall_b),
    .memory_request (req_b),
    .memory_addr    (maddr_b),
    .memory_ready   (rdy_b),
    .memory_data    (data_b)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count      (hc_b),
    .miss_count     (mc_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        fv;
    logic [63:0] addr;
    logic        rdy;
    logic [31:0] data;
    logic        exp_iv;
    logic        exp_hit;
    logic        exp_stall;
    logic        exp_req;
    logic        chk_maddr;
    logic [63:0] exp_maddr;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic fv, input logic [63:0] addr, input logic rdy,
                              input logic [31:0] data, input logic iv, input logic h,
                              input logic st, input logic rq, input logic cm,
                              input logic [63:0] ma, input logic [31:0] ins);
    vec_t v;
    v.fv = fv; v.addr = addr; v.rdy = rdy; v.data = data;
    v.exp_iv = iv; v.exp_hit = h; v.exp_stall = st; v.exp_req = rq;
    v.chk_maddr = cm; v.exp_maddr = ma; v.exp_instr = ins;
    return v;
  endfunction

  // Backing-memory contents: every word-aligned address holds a unique pattern.
  function automatic logic [31:0] mdl(input logic [63:0] a);
    return 32'hCAFE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full miss + refill on the default DUT. period = cycles between ready beats.
  task automatic refill_a(input logic [63:0] a, input int period, input bit scramble,
                          input string nm);
    logic [63:0] base;
    logic [31:0] got;
    int          beats, ivs;
    bit          done, req_drop;
    base = {a[63:4], 4'h0};
    got = '0; beats = 0; ivs = 0; done = 0; req_drop = 0;
    fv_a = 1'b1; addr_a = a; rdy_a = 1'b0; flush_a = 1'b0;
    tick();
    chk({nm, "_miss_stall"}, stall_a, 1);
    chk({nm, "_miss_req"}, req_a, 1);
    chk({nm, "_miss_hit"}, hit_a, 0);
    for (int k = 0; k < 200 && !done; k++) begin
      rdy_a = ((k % period) == period - 1);
      if (rdy_a) begin
        chk({nm, "_beat_addr"}, maddr_a, base + 64'(4 * beats));
        data_a = mdl(base + 64'(4 * beats));
        beats++;
      end else begin
        data_a = 32'h0BAD_0BAD;
      end
      if (scramble) begin
        fv_a   = 1'($urandom_range(0, 1));
        addr_a = {32'h0, $urandom()};
      end
      tick();
      if (iv_a) begin
        ivs++;
        got  = instr_a;
        done = 1;
        chk({nm, "_resp_hit"}, hit_a, 0);
        chk({nm, "_resp_stall"}, stall_a, 0);
      end else if (!req_a) begin
        req_drop = 1;
      end
    end
    chk({nm, "_completed"}, done, 1);
    fv_a = 1'b0; rdy_a = 1'b0;
    tick();
    if (iv_a) ivs++;
    chk({nm, "_beats"}, beats, 4);
    chk({nm, "_iv_pulses"}, ivs, 1);
    chk({nm, "_req_held"}, req_drop, 0);
    chk({nm, "_instr"}, got, mdl({a[63:2], 2'b00}));
  endtask

  initial begin
    rst_a = 1'b1; fv_a = 1'b0; flush_a = 1'b0; rdy_a = 1'b0; addr_a = '0; data_a = '0;
    rst_b = 1'b1; fv_b = 1'b0; flush_b = 1'b0; rdy_b = 1'b0; addr_b = '0; data_b = '0;

    tbl[0] = mk(1, 64'h1004, 1, 32'hDEAD_BEEF, 0, 0, 1, 1, 1, 64'h1000, 32'h0);
    tbl[1] = mk(1, 64'h1004, 1, 32'hA0,        0, 0, 1, 1, 1, 64'h1004, 32'h0);
    tbl[2] = mk(1, 64'h1004, 1, 32'hA1,        0, 0, 1, 1, 1, 64'h1008, 32'h0);
    tbl[3] = mk(0, 64'h0,    1, 32'hA2,        0, 0, 1, 1, 1, 64'h100C, 32'h0);
    tbl[4] = mk(1, 64'h9990, 1, 32'hA3,        1, 0, 0, 0, 0, 64'h0,    32'hA1);
    tbl[5] = mk(0, 64'h0,    0, 32'h0,         0, 0, 0, 0, 0, 64'h0,    32'h0);
    tbl[6] = mk(1, 64'h1000, 0, 32'h0,         1, 1, 0, 0, 0, 64'h0,    32'hA0);
    tbl[7] = mk(1, 64'h1008, 1, 32'h0BAD,      1, 1, 0, 0, 0, 64'h0,    32'hA2);
    tbl[8] = mk(1, 64'h100C, 0, 32'h0,         1, 1, 0, 0, 0, 64'h0,    32'hA3);
    tbl[9] = mk(0, 64'h0,    0, 32'h0,         0, 0, 0, 0, 0, 64'h0,    32'h0);

    tick(); tick();
    chk("rst_instr", instr_a, 0);
    chk("rst_iv", iv_a, 0);
    chk("rst_hit", hit_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_req", req_a, 0);
    chk("rst_maddr", maddr_a, 0);
    chk("rst_b_req", req_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Cold miss on 0x1004 followed by back-to-back hits
    for (int i = 0; i < 10; i++) begin
      fv_a = tbl[i].fv; addr_a = tbl[i].addr; rdy_a = tbl[i].rdy; data_a = tbl[i].data;
      tick();
      chk($sformatf("vec%0d_iv", i), iv_a, tbl[i].exp_iv);
      chk($sformatf("vec%0d_hit", i), hit_a, tbl[i].exp_hit);
      chk($sformatf("vec%0d_stall", i), stall_a, tbl[i].exp_stall);
      chk($sformatf("vec%0d_req", i), req_a, tbl[i].exp_req);
      if (tbl[i].chk_maddr) chk($sformatf("vec%0d_maddr", i), maddr_a, tbl[i].exp_maddr);
      if (tbl[i].exp_iv) chk($sformatf("vec%0d_instr", i), instr_a, tbl[i].exp_instr);
    end

    // Conflict eviction: same index, different tag, then the old line misses
    refill_a(64'h2004, 1, 0, "conflict_new");
    refill_a(64'h1004, 1, 0, "conflict_old");

    // Slow memory with address/fetch_valid churn during refill
    refill_a(64'h3008, 3, 1, "slow");
    fv_a = 1'b1; addr_a = 64'h3000;
    tick();
    chk("slow_rehit_hit", hit_a, 1);
    chk("slow_rehit_instr", instr_a, mdl(64'h3000));
    fv_a = 1'b0;
    tick();

    // Flush after two beats
    fv_a = 1'b1; addr_a = 64'h4004;
    tick();
    fv_a = 1'b0;
    rdy_a = 1'b1; data_a = mdl(64'h4000); tick();
    rdy_a = 1'b1; data_a = mdl(64'h4004); tick();
    chk("flush_pre_maddr", maddr_a, 64'h4008);
    flush_a = 1'b1; rdy_a = 1'b1; data_a = 32'h1111_1111;
    tick();
    chk("flush_req", req_a, 0);
    chk("flush_stall", stall_a, 0);
    chk("flush_iv", iv_a, 0);
    flush_a = 1'b0; rdy_a = 1'b0;
    tick();
    chk("flush_post_iv", iv_a, 0);
    chk("flush_post_req", req_a, 0);
    refill_a(64'h4004, 1, 0, "flush_refetch");

    // Flush in IDLE drops a coincident fetch and invalidates the line
    fv_a = 1'b1; addr_a = 64'h4008;
    tick();
    chk("idle_hit_before_flush", hit_a, 1);
    chk("idle_hit_instr", instr_a, mdl(64'h4008));
    flush_a = 1'b1;
    tick();
    chk("idle_flush_iv", iv_a, 0);
    chk("idle_flush_stall", stall_a, 0);
    flush_a = 1'b0; fv_a = 1'b0;
    tick();
    refill_a(64'h4008, 1, 0, "idle_flush_refetch");

    // Reset mid-refill
    fv_a = 1'b1; addr_a = 64'h5004;
    tick();
    rdy_a = 1'b1; data_a = mdl(64'h5000); tick();
    rdy_a = 1'b1; data_a = mdl(64'h5004); tick();
    rst_a = 1'b1;
    tick();
    chk("rst_mid_instr", instr_a, 0);
    chk("rst_mid_iv", iv_a, 0);
    chk("rst_mid_hit", hit_a, 0);
    chk("rst_mid_stall", stall_a, 0);
    chk("rst_mid_req", req_a, 0);
    chk("rst_mid_maddr", maddr_a, 0);
    rst_a = 1'b0; fv_a = 1'b0; rdy_a = 1'b0;
    tick();
    refill_a(64'h5004, 1, 0, "rst_refetch");

    // 8-word lines: fetch 0x1C refills 0x00..0x1C and returns beat 7
    fv_b = 1'b1; addr_b = 64'h1C;
    tick();
    chk("sweep_req", req_b, 1);
    chk("sweep_stall", stall_b, 1);
    fv_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sweep_maddr%0d", k), maddr_b, 64'(4 * k));
      rdy_b = 1'b1; data_b = mdl(64'(4 * k));
      tick();
      chk($sformatf("sweep_iv%0d", k), iv_b, (k == 7));
    end
    chk("sweep_instr", instr_b, mdl(64'h1C));
    chk("sweep_hit0", hit_b, 0);
    rdy_b = 1'b0;
    tick();
    chk("sweep_iv_single", iv_b, 0);
`ifdef ICACHE_STATS_EN
    chk("stats_miss", mc_b, 1);
    chk("stats_hit0", hc_b, 0);
`endif
    fv_b = 1'b1; addr_b = 64'h00;
    tick();
    chk("sweep_hit_a", hit_b, 1);
    chk("sweep_hit_a_instr", instr_b, mdl(64'h00));
`ifdef ICACHE_STATS_EN
    chk("stats_hit1", hc_b, 1);
`endif
    addr_b = 64'h10;
    tick();
    chk("sweep_hit_b", hit_b, 1);
    chk("sweep_hit_b_instr", instr_b, mdl(64'h10));
`ifdef ICACHE_STATS_EN
    chk("stats_hit2", hc_b, 2);
    chk("stats_miss_still", mc_b, 1);
`endif
    fv_b = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
